simd_wr_commit: RTL
===================

SIMD_WR_COMMIT -- requirements
Module: simd_wr_commit

Interface
REQ-001 SHALL have parameter NS_ID_BITS, default 3, namespace id width.
REQ-002 SHALL have parameter NS_INDEX_ID_BITS, default 5, namespace index id width.
REQ-003 SHALL have parameter BASE_STRIDE_WIDTH, default 4*(NS_INDEX_ID_BITS+NS_ID_BITS), write address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, entries of commit queue.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port buf_wr_req_in  input  6  one-hot namespace write request from execute pipeline; all-zero = no write.
REQ-009 SHALL have port buf_wr_addr_in  input  BASE_STRIDE_WIDTH  write address, qualified by buf_wr_req_in.
REQ-010 SHALL have port buf_wr_data_in  input  DATA_WIDTH  write data, qualified by buf_wr_req_in.
REQ-011 SHALL have port ns_wr_ready  input  6  per-namespace bank ready.
REQ-012 SHALL have port ns_wr_en  output  6  one-hot bank write strobe.
REQ-013 SHALL have port ns_wr_addr  output  BASE_STRIDE_WIDTH  shared bank write address.
REQ-014 SHALL have port ns_wr_data  output  DATA_WIDTH  shared bank write data.
REQ-015 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-016 SHALL have ports overflow_err, multi_hot_err  output  1 each  sticky error flags.
REQ-017 SHALL have port stall_cycles  output  16  saturating count of cycles head entry waited on ns_wr_ready.
REQ-018 SHALL have port idle  output  1  high when queue empty and no strobe issued this cycle.

Function
REQ-019 Push: cycle with exactly one bit of buf_wr_req_in set SHALL enqueue {req, addr, data}; upstream has no backpressure, input always sampled.
REQ-020 buf_wr_req_in with >1 bit set SHALL be dropped and SHALL set multi_hot_err.
REQ-021 Issue: when queue non-empty and ns_wr_ready[head.req] = 1, ns_wr_en SHALL equal head.req with head addr/data, and head SHALL pop that cycle.
REQ-022 Strict in-order: a stalled head SHALL block all later entries, no reordering, no write to a non-ready bank.
REQ-023 At most one bit of ns_wr_en SHALL be high per cycle; ns_wr_en SHALL be 0 when queue empty (bypass excepted, REQ-032); addr/data SHALL be 0 when ns_wr_en = 0.
REQ-024 Latency without bypass: write pushed in cycle N SHALL reach ns_wr_en no earlier than cycle N+1, exactly N+1 when queue empty and bank ready.
REQ-025 Full queue with simultaneous pop SHALL accept the push.
REQ-026 Full queue without pop SHALL drop the push, leave contents unchanged, set overflow_err.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit to distinguish full from empty.
REQ-028 stall_cycles SHALL increment each cycle queue non-empty and head bank not ready, saturating at 16'hFFFF; never cleared except by reset.
REQ-029 clr_err SHALL clear both sticky flags next edge; same-cycle new error SHALL win (flag stays set).

Reset
REQ-030 reset low SHALL asynchronously empty queue, zero pointers, stall_cycles, overflow_err, multi_hot_err; ns_wr_en = 0, idle = 1.
REQ-031 Reset asserted mid-operation SHALL discard all queued writes; no strobe SHALL issue while reset low or on the first edge after release.

Configuration
REQ-032 With SIMD_WR_BYPASS_EN defined: queue empty and ns_wr_ready[buf_wr_req_in] = 1 SHALL drive the input combinationally onto ns_wr_en/addr/data same cycle (latency 0) without enqueueing; otherwise REQ-024 applies.
REQ-033 Without SIMD_WR_BYPASS_EN: no combinational path from buf_wr_* inputs to ns_wr_* outputs.

Verification
REQ-034 Empty queue, all ready, push req=6'b000100 addr=32'h10 data=32'hA5 at cycle 0 -> ns_wr_en=6'b000100, addr 32'h10, data 32'hA5 at cycle 1 (cycle 0 with bypass).
REQ-035 ns_wr_ready=0, push 5 writes with FIFO_DEPTH=4 -> 4 queued, overflow_err=1, stall_cycles increments each cycle; raise ready -> 4 writes in push order, one per cycle.
REQ-036 Queue full, ready high, push same cycle as pop -> no overflow, all pushed writes emerge in order.
REQ-037 Push req=6'b000011 -> dropped, multi_hot_err=1, ns_wr_en stays 0; clr_err pulse -> flag 0.
REQ-038 Head bank 2 not ready, next entry bank 5 ready -> bank 5 write withheld until bank 2 issues.
REQ-039 reset low with 3 entries queued -> ns_wr_en=0 immediately, idle=1, counters 0, no queued write issues after release.

Source files
------------

// File: rtl/simd_wr_commit.sv
// Commit queue: holds one-hot namespace writes from execute and retires them in order to the banks.
// Latency: one cycle from push to ns_wr_en when the queue is empty and the bank is ready. With SIMD_WR_BYPASS_EN defined this drops to zero.
// Backpressure: upstream is never stalled; a full queue with no pop drops the push and sets overflow_err.
module simd_wr_commit #(
    parameter int NS_ID_BITS        = 3,
    parameter int NS_INDEX_ID_BITS  = 5,
    parameter int BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS),
    parameter int DATA_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [5:0]                   buf_wr_req_in,
    input  logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in,
    input  logic [DATA_WIDTH-1:0]        buf_wr_data_in,
    input  logic [5:0]                   ns_wr_ready,
    output logic [5:0]                   ns_wr_en,
    output logic [BASE_STRIDE_WIDTH-1:0] ns_wr_addr,
    output logic [DATA_WIDTH-1:0]        ns_wr_data,
    input  logic                         clr_err,
    output logic                         overflow_err,
    output logic                         multi_hot_err,
    output logic [15:0]                  stall_cycles,
    output logic                         idle
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [5:0]                   req;
        logic [BASE_STRIDE_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]        data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        in_ent;
    entry_t        head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          in_vld;
    logic          in_multi;
    logic          head_rdy;
    logic          bypass;
    logic          push;
    logic          ovf;
    logic          stall;

    assign in_ent = '{req: buf_wr_req_in, addr: buf_wr_addr_in, data: buf_wr_data_in};
    assign head   = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_vld   = (buf_wr_req_in != 6'd0) && ((buf_wr_req_in & (buf_wr_req_in - 6'd1)) == 6'd0);
    assign in_multi = (buf_wr_req_in != 6'd0) && !in_vld;
    assign head_rdy = !empty && (|(head.req & ns_wr_ready));

`ifdef SIMD_WR_BYPASS_EN
    assign bypass = empty && in_vld && (|(buf_wr_req_in & ns_wr_ready));
`else
    assign bypass = 1'b0;
`endif

    assign push  = in_vld && !bypass && (!full || head_rdy);
    assign ovf   = in_vld && full && !head_rdy;
    assign stall = !empty && !head_rdy;

    always_comb begin
        ns_wr_en   = 6'd0;
        ns_wr_addr = '0;
        ns_wr_data = '0;
        if (head_rdy) begin
            ns_wr_en   = head.req;
            ns_wr_addr = head.addr;
            ns_wr_data = head.data;
        end
`ifdef SIMD_WR_BYPASS_EN
        else if (bypass) begin
            ns_wr_en   = buf_wr_req_in;
            ns_wr_addr = buf_wr_addr_in;
            ns_wr_data = buf_wr_data_in;
        end
`endif
    end

    assign idle = empty && (ns_wr_en == 6'd0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            stall_cycles  <= 16'd0;
            overflow_err  <= 1'b0;
            multi_hot_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (head_rdy)
                rd_ptr <= rd_ptr + 1'b1;
            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            // A new error in the same cycle as clr_err keeps the flag set.
            if (ovf)
                overflow_err <= 1'b1;
            else if (clr_err)
                overflow_err <= 1'b0;
            if (in_multi)
                multi_hot_err <= 1'b1;
            else if (clr_err)
                multi_hot_err <= 1'b0;
        end
    end
endmodule
